// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-command parser driving the native mem_valid/mem_ready bus
// Optional feature macro: UART_BUS_MASTER_ACK_EN ('K' after writes, 'E' after timeouts)
module uart_bus_master #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] CMD_WRITE      = 8'h57,
  parameter logic [7:0] CMD_READ       = 8'h52
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_cmd,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TONE  = TW'(1);

`ifdef UART_BUS_MASTER_ACK_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, ACK} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
`endif

  state_t        state;
  logic          is_write;
  logic [1:0]    cnt;
  logic [TW-1:0] tcnt;
  // Upper three read-data bytes, shifted down as each response byte is accepted
  logic [23:0]   rdata_hi;

  // This port never fetches instructions
  assign mem_instr = 1'b0;

  // Command parser, bus handshake, timeout and response sequencer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      cnt         <= 2'd0;
      tcnt        <= '0;
      rdata_hi    <= 24'h0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      mem_valid   <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      busy        <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write  <= (rx_data == CMD_WRITE);
              mem_wstrb <= (rx_data == CMD_WRITE) ? 4'hF : 4'h0;
              cnt       <= 2'd0;
              state     <= ADDR;
              busy      <= 1'b1;
            end else begin
              err_cmd <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            // Word-aligned bus: the two address LSBs are dropped as byte 0 arrives
            mem_addr[{cnt, 3'b000} +: 8] <= (cnt == 2'd0) ? (rx_data & 8'hFC) : rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (is_write) begin
                state <= DATA;
              end else begin
                state <= BUS;
                tcnt  <= '0;
              end
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            mem_wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= BUS;
              tcnt  <= '0;
            end
          end
        end
        BUS: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (!mem_valid) begin
            // Entry cycle: raise the request one cycle after the last byte
            mem_valid <= 1'b1;
            tcnt      <= '0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            if (is_write) begin
`ifdef UART_BUS_MASTER_ACK_EN
              state    <= ACK;
              tx_valid <= 1'b1;
              tx_data  <= 8'h4B;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              rdata_hi <= mem_rdata[31:8];
              tx_data  <= mem_rdata[7:0];
              tx_valid <= 1'b1;
              cnt      <= 2'd0;
              state    <= RESP;
            end
          end else if (tcnt == TLAST) begin
            mem_valid   <= 1'b0;
            err_timeout <= 1'b1;
`ifdef UART_BUS_MASTER_ACK_EN
            state    <= ACK;
            tx_valid <= 1'b1;
            tx_data  <= 8'h45;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            tcnt <= tcnt + TONE;
          end
        end
        RESP: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (tx_valid && tx_ready) begin
            if (cnt == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              tx_data  <= rdata_hi[7:0];
              rdata_hi <= {8'h00, rdata_hi[23:8]};
              cnt      <= cnt + 2'd1;
            end
          end
        end
`ifdef UART_BUS_MASTER_ACK_EN
        ACK: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tx_valid  <= 1'b0;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed table-driven bench for uart_bus_master
module tb_uart_bus_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err_cmd;
  logic        err_timeout;
  logic        err_overrun;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .err_cmd(err_cmd),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  int total = 0;
  int bad = 0;

  int          slave_delay = 0;
  bit          slave_stuck = 1'b0;
  int          tx_stall = 0;
  logic [31:0] slave_rdata = 32'h0;
  assign mem_rdata = slave_rdata;

  int          mv_cycles, mv_rises, hs_count, ecmd, eto, eov, stab_err;
  logic [31:0] hs_addr, hs_wdata;
  logic [3:0]  hs_wstrb;
  logic [7:0]  tx_q[$];
  logic        prev_mv = 1'b0;
  logic        prev_wait = 1'b0;
  logic [7:0]  prev_td = 8'h00;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          stall;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t vecs[5];

  // Memory slave: mem_ready after slave_delay waiting cycles, never while stuck
  initial begin : slave
    int w;
    w = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid && !slave_stuck) begin
        if (w >= slave_delay) begin
          mem_ready = 1'b1;
          w = 0;
        end else begin
          mem_ready = 1'b0;
          w++;
        end
      end else begin
        mem_ready = 1'b0;
        w = 0;
      end
    end
  end

  // Transmitter: holds tx_ready low tx_stall cycles per offered byte
  initial begin : txsink
    int s;
    s = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_valid) begin
        if (s >= tx_stall) begin
          tx_ready = 1'b1;
          s = 0;
        end else begin
          tx_ready = 1'b0;
          s++;
        end
      end else begin
        tx_ready = 1'b0;
        s = 0;
      end
    end
  end

  // Mid-cycle observer of bus handshakes, transmitted bytes and error pulses
  always @(negedge clk) begin
    if (mem_valid) begin
      mv_cycles++;
      if (!prev_mv) mv_rises++;
      if (mem_ready) begin
        hs_count++;
        hs_addr  = mem_addr;
        hs_wdata = mem_wdata;
        hs_wstrb = mem_wstrb;
      end
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (prev_wait && tx_valid && tx_data !== prev_td) stab_err++;
    prev_wait = tx_valid && !tx_ready;
    prev_td   = tx_data;
    prev_mv   = mem_valid;
    if (err_cmd) ecmd++;
    if (err_timeout) eto++;
    if (err_overrun) eov++;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    mv_cycles = 0; mv_rises = 0; hs_count = 0;
    ecmd = 0; eto = 0; eov = 0; stab_err = 0;
    hs_addr = 32'h0; hs_wdata = 32'h0; hs_wstrb = 4'h0;
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check(name, {31'h0, busy}, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_tx4(input string name, input logic [31:0] exp);
    check({name, "_ntx"}, tx_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (tx_q.size() > k) check({name, "_txbyte"}, {24'h0, tx_q[k]}, {24'h0, exp[8*k +: 8]});
  endtask

  initial begin : main
    bit seen;
    clear_stats();

    vecs[0] = '{1'b1, 32'h00010000, 32'hDEADBEEF, 32'h0,        2, 0, 32'h00010000, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h00010004, 32'h0,        32'h12345678, 0, 5, 32'h00010004, 4'h0, 32'h12345678};
    vecs[2] = '{1'b0, 32'h00000000, 32'h0,        32'hA5C30F01, 1, 0, 32'h00000000, 4'h0, 32'hA5C30F01};
    vecs[3] = '{1'b1, 32'h20000003, 32'h01020304, 32'h0,        0, 0, 32'h20000000, 4'hF, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFFFFFE, 32'h0,        32'h80000001, 3, 1, 32'hFFFFFFFC, 4'h0, 32'h80000001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_mem_instr", {31'h0, mem_instr}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_errs", {29'h0, err_cmd, err_timeout, err_overrun}, 32'h0);
    resetn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      clear_stats();
      slave_delay = vecs[v].delay;
      tx_stall    = vecs[v].stall;
      slave_rdata = vecs[v].rdata;
      send_cmd(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      wait_idle("vec_idle");
      check("vec_hs_count", hs_count, 1);
      check("vec_mv_rises", mv_rises, 1);
      check("vec_mv_cycles", mv_cycles, vecs[v].delay + 1);
      check("vec_addr", hs_addr, vecs[v].exp_addr);
      check("vec_wstrb", {28'h0, hs_wstrb}, {28'h0, vecs[v].exp_wstrb});
      check("vec_stable", stab_err, 0);
      if (vecs[v].wr) begin
        check("vec_wdata", hs_wdata, vecs[v].wdata);
`ifdef UART_BUS_MASTER_ACK_EN
        check("vec_ack_ntx", tx_q.size(), 1);
        if (tx_q.size() > 0) check("vec_ack_byte", {24'h0, tx_q[0]}, 32'h4B);
`else
        check("vec_write_ntx", tx_q.size(), 0);
`endif
      end else begin
        check_tx4("vec_read", vecs[v].exp_tx);
      end
    end

    // Unknown opcode, then a normal read
    clear_stats();
    tx_stall = 0; slave_delay = 0; slave_rdata = 32'h0BADF00D;
    send_byte(8'h41);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("badop_err_cmd", ecmd, 1);
    check("badop_busy", {31'h0, busy}, 32'h0);
    send_cmd(1'b0, 32'h0, 32'h0);
    wait_idle("badop_idle");
    check("badop_hs", hs_count, 1);
    check("badop_addr", hs_addr, 32'h0);
    check_tx4("badop_read", 32'h0BADF00D);

    // Timeout: read with the slave never responding
    clear_stats();
    slave_stuck = 1'b1;
    send_cmd(1'b0, 32'h80000100, 32'h0);
    wait_idle("to_idle");
    check("to_mv_cycles", mv_cycles, TO);
    check("to_mv_rises", mv_rises, 1);
    check("to_err", eto, 1);
    check("to_hs", hs_count, 0);
`ifdef UART_BUS_MASTER_ACK_EN
    check("to_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("to_err_byte", {24'h0, tx_q[0]}, 32'h45);
`else
    check("to_ntx", tx_q.size(), 0);
`endif
    slave_stuck = 1'b0;

    // Overrun: byte arrives during the response
    clear_stats();
    tx_stall = 5; slave_rdata = 32'hCAFEF00D;
    send_cmd(1'b0, 32'h00000010, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("ovr_resp_seen", {31'h0, seen}, 32'h1);
    send_byte(8'h33);
    wait_idle("ovr_idle");
    check("ovr_err", eov, 1);
    check("ovr_no_cmd_err", ecmd, 0);
    check("ovr_stable", stab_err, 0);
    check_tx4("ovr_read", 32'hCAFEF00D);

    // Reset while the bus request is outstanding
    clear_stats();
    tx_stall = 0; slave_stuck = 1'b1;
    send_cmd(1'b0, 32'h00000020, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rstbus_mv_seen", {31'h0, seen}, 32'h1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rstbus_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rstbus_busy", {31'h0, busy}, 32'h0);
    check("rstbus_tx_valid", {31'h0, tx_valid}, 32'h0);
    resetn = 1'b1;
    slave_stuck = 1'b0;
    clear_stats();
    slave_delay = 1;
    send_cmd(1'b1, 32'h00000044, 32'h55AA1234);
    wait_idle("rstbus_idle");
    check("rstbus_hs", hs_count, 1);
    check("rstbus_addr", hs_addr, 32'h00000044);
    check("rstbus_wdata", hs_wdata, 32'h55AA1234);
    check("rstbus_wstrb", {28'h0, hs_wstrb}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
